pixel_stream_sink: RTL and testbench

- AXI4-Stream video receiver: the consuming end of the pixel generator's out_stream.
- Accepts 32-bit pixel beats and tracks x/y position per frame.
- Checks framing markers: tuser = start of frame, tlast = end of line or end of frame.
- Accumulates a per-frame checksum and exposes frame/error status to a host or testbench for loopback checking.

---
 rtl/pixel_stream_sink.sv | 191 +++++++++++++++++++
 tb/tb_pixel_stream_sink.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_sink.sv
// -----------------------------------------------------------------------------
// pixel_stream_sink
//
// AXI4-Stream video receiver. It consumes 32-bit pixel beats, tracks the
// (x, y) position of the next expected pixel, and checks the framing markers:
// tuser marks start of frame, and tlast marks end of line or end of frame.
// It sums every pixel of a frame modulo 2^32. When a frame completes cleanly,
// it pulses frame_done, increments frame_count and latches frame_checksum.
// Framing violations set sticky err_flags and increment a saturating err_count.
//
// Parameters:
//   X_SIZE        pixels per line (at most 1024)
//   Y_SIZE        lines per frame (at most 1024)
//   LAST_PER_LINE 1: tlast on the last pixel of every line
//                 0: tlast only on the last pixel of the frame
//
// Ports:
//   in_stream_aclk    stream clock, rising edge
//   axi_resetn        asynchronous active-low reset
//   in_stream_tdata   pixel data
//   in_stream_tkeep   byte enables, must be 4'hF
//   in_stream_tlast   end-of-line / end-of-frame marker
//   in_stream_tuser   start-of-frame marker
//   in_stream_tvalid  source has a beat
//   in_stream_tready  sink accepts a beat
//   ready_en          0 stalls the sink (forces tready low)
//   clear_err         one-cycle pulse that clears err_flags and err_count
//   x, y              position of the next expected pixel
//   frame_done        one-cycle pulse after the last pixel of a good frame
//   frame_count       number of good frames received (wraps)
//   frame_checksum    sum of all tdata in the last good frame
//   err_flags         sticky flags:
//                       [0] early/late tuser
//                       [1] missing tlast
//                       [2] unexpected tlast
//                       [3] bad tkeep
//   err_count         errors detected, saturating at 255
//
// Optional feature, enabled by defining PIXEL_SINK_BACKPRESSURE_EN:
//   A 16-bit LFSR gates tready to produce pseudo-random backpressure.
// -----------------------------------------------------------------------------
module pixel_stream_sink #(
  parameter int X_SIZE        = 640,
  parameter int Y_SIZE        = 480,
  parameter int LAST_PER_LINE = 1
) (
  input  logic        in_stream_aclk,
  input  logic        axi_resetn,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  input  logic        ready_en,
  input  logic        clear_err,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic [31:0] frame_checksum,
  output logic [3:0]  err_flags,
  output logic [7:0]  err_count
);

  typedef enum logic {WAIT_SOF = 1'b0, RECV = 1'b1} state_t;

  localparam logic [9:0] X_MAX = 10'(X_SIZE - 1);
  localparam logic [9:0] Y_MAX = 10'(Y_SIZE - 1);

  state_t      state, state_n;
  logic [9:0]  x_n, y_n, px, py;
  logic [31:0] sum, sum_n, sum_acc, frame_checksum_n;
  logic [15:0] frame_count_n;
  logic [3:0]  err_set, err_flags_n;
  logic [7:0]  err_base, err_count_n;
  logic        frame_done_n, live, accept, sof, pixel, tuser_err;
  logic        last_col, last_pix, tlast_exp;

  // tready comes from registered state only. The live flop keeps tready low
  // until the first clock edge after reset is released.
`ifdef PIXEL_SINK_BACKPRESSURE_EN
  logic [15:0] lfsr;

  always_ff @(posedge in_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) lfsr <= 16'hACE1;
    else             lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign in_stream_tready = live & ready_en & (lfsr[0] | lfsr[1]);
`else
  assign in_stream_tready = live & ready_en;
`endif

  assign accept = in_stream_tvalid & in_stream_tready;
  assign sof    = in_stream_tuser;
  // In WAIT_SOF, only a tuser beat is a pixel; any other beat is drained.
  assign pixel  = accept & ((state == RECV) | sof);
  // A tuser beat in mid-frame is an error, but it still restarts the frame.
  assign tuser_err = (state == RECV) & sof & ((x != 10'd0) | (y != 10'd0));
  // A start-of-frame beat is always treated as pixel (0,0).
  assign px        = sof ? 10'd0 : x;
  assign py        = sof ? 10'd0 : y;
  assign last_col  = (px == X_MAX);
  assign last_pix  = last_col & (py == Y_MAX);
  assign tlast_exp = (LAST_PER_LINE != 0) ? last_col : last_pix;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_n          = state;
    x_n              = x;
    y_n              = y;
    sum_n            = sum;
    sum_acc          = (sof ? 32'd0 : sum) + in_stream_tdata;
    frame_done_n     = 1'b0;
    frame_count_n    = frame_count;
    frame_checksum_n = frame_checksum;
    err_set          = 4'd0;

    if (pixel) begin
      if (in_stream_tkeep != 4'hF) begin
        err_set[3] = 1'b1;
        state_n    = WAIT_SOF;
        x_n        = 10'd0;
        y_n        = 10'd0;
        sum_n      = 32'd0;
      end else if (tuser_err) begin
        // The restarted frame starts from this beat, which becomes pixel (0,0).
        err_set[0] = 1'b1;
        state_n    = RECV;
        x_n        = 10'd1;
        y_n        = 10'd0;
        sum_n      = in_stream_tdata;
      end else if (in_stream_tlast != tlast_exp) begin
        err_set[in_stream_tlast ? 2 : 1] = 1'b1;
        state_n = WAIT_SOF;
        x_n     = 10'd0;
        y_n     = 10'd0;
        sum_n   = 32'd0;
      end else if (last_pix) begin
        frame_done_n     = 1'b1;
        frame_count_n    = frame_count + 16'd1;
        frame_checksum_n = sum_acc;
        state_n          = WAIT_SOF;
        x_n              = 10'd0;
        y_n              = 10'd0;
        sum_n            = 32'd0;
      end else begin
        state_n = RECV;
        sum_n   = sum_acc;
        x_n     = last_col ? 10'd0 : px + 10'd1;
        y_n     = last_col ? py + 10'd1 : py;
      end
    end

    // clear_err drops the old status before any error from this beat is added.
    err_base    = clear_err ? 8'd0 : err_count;
    err_flags_n = (clear_err ? 4'd0 : err_flags) | err_set;
    err_count_n = ((|err_set) && (err_base != 8'hFF)) ? err_base + 8'd1 : err_base;
  end

  always_ff @(posedge in_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state          <= WAIT_SOF;
      live           <= 1'b0;
      x              <= 10'd0;
      y              <= 10'd0;
      sum            <= 32'd0;
      frame_done     <= 1'b0;
      frame_count    <= 16'd0;
      frame_checksum <= 32'd0;
      err_flags      <= 4'd0;
      err_count      <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the values
      // from before this clock edge, whatever the statement order.
      state          <= state_n;
      live           <= 1'b1;
      x              <= x_n;
      y              <= y_n;
      sum            <= sum_n;
      frame_done     <= frame_done_n;
      frame_count    <= frame_count_n;
      frame_checksum <= frame_checksum_n;
      err_flags      <= err_flags_n;
      err_count      <= err_count_n;
    end
  end

endmodule

// File: tb/tb_pixel_stream_sink.sv
// -----------------------------------------------------------------------------
// tb_pixel_stream_sink
//
// Self-checking bench for pixel_stream_sink, configured as a 4x2 frame with
// tlast at the end of every line. A reference model tracks the frame as a
// linear pixel index plus an in-frame bit. A compare process checks every DUT
// output against the model on each falling clock edge. Directed scenarios add
// hand-computed literal expectations. A randomized phase follows, with random
// stall patterns and injected framing errors.
// -----------------------------------------------------------------------------
module tb_pixel_stream_sink;

  localparam int X   = 4;
  localparam int Y   = 2;
  localparam int LPL = 1;
  localparam int NPX = X * Y;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tuser, tvalid, tready;
  logic        ready_en = 1'b1;
  logic        clear_err;
  logic [9:0]  x, y;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [31:0] frame_checksum;
  logic [3:0]  err_flags;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;
  int rdy_mode = 0;

  pixel_stream_sink #(.X_SIZE(X), .Y_SIZE(Y), .LAST_PER_LINE(LPL)) dut (
    .in_stream_aclk  (clk),
    .axi_resetn      (rst_n),
    .in_stream_tdata (tdata),
    .in_stream_tkeep (tkeep),
    .in_stream_tlast (tlast),
    .in_stream_tuser (tuser),
    .in_stream_tvalid(tvalid),
    .in_stream_tready(tready),
    .ready_en        (ready_en),
    .clear_err       (clear_err),
    .x               (x),
    .y               (y),
    .frame_done      (frame_done),
    .frame_count     (frame_count),
    .frame_checksum  (frame_checksum),
    .err_flags       (err_flags),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: position is a linear pixel index within the frame.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    bit          in_frame;
    int          pix;
    logic [31:0] sum;
    logic [15:0] count;
    logic [31:0] cks;
    logic [3:0]  flags;
    int          errs;
    bit          done;
    bit          live;
    logic [15:0] lfsr;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r.in_frame = 1'b0;
    r.pix      = 0;
    r.sum      = '0;
    r.count    = '0;
    r.cks      = '0;
    r.flags    = '0;
    r.errs     = 0;
    r.done     = 1'b0;
    r.live     = 1'b0;
    r.lfsr     = 16'hACE1;
    return r;
  endfunction

  model_t m = model_reset();

  function automatic bit model_tready(model_t s, logic ren);
`ifdef PIXEL_SINK_BACKPRESSURE_EN
    return s.live && ren && (s.lfsr[0] || s.lfsr[1]);
`else
    return s.live && ren;
`endif
  endfunction

  function automatic model_t model_step(model_t s, bit acc, logic [31:0] d, bit u,
                                       bit l, logic [3:0] k, bit clr);
    model_t n = s;
    int     err = -1;
    int     idx;
    bit     exp_last;
    n.done = 1'b0;
    n.live = 1'b1;
    n.lfsr = {s.lfsr[14:0], s.lfsr[15] ^ s.lfsr[13] ^ s.lfsr[12] ^ s.lfsr[10]};
    if (acc && (s.in_frame || u)) begin
      idx      = u ? 0 : s.pix;
      exp_last = (LPL != 0) ? ((idx % X) == X - 1) : (idx == NPX - 1);
      if (k != 4'hF) begin
        err = 3; n.in_frame = 1'b0; n.pix = 0; n.sum = '0;
      end else if (s.in_frame && u && s.pix != 0) begin
        err = 0; n.sum = d; n.pix = 1;
      end else if (l != exp_last) begin
        err = l ? 2 : 1; n.in_frame = 1'b0; n.pix = 0; n.sum = '0;
      end else begin
        n.sum = (u ? 32'd0 : s.sum) + d;
        if (idx == NPX - 1) begin
          n.count = s.count + 16'd1; n.cks = n.sum; n.done = 1'b1;
          n.in_frame = 1'b0; n.pix = 0; n.sum = '0;
        end else begin
          n.pix = idx + 1; n.in_frame = 1'b1;
        end
      end
    end
    if (clr) begin
      n.flags = '0; n.errs = 0;
    end
    if (err >= 0) begin
      n.flags[err] = 1'b1;
      if (n.errs < 255) n.errs = n.errs + 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else m <= model_step(m, tvalid && model_tready(m, ready_en), tdata, tuser,
                         tlast, tkeep, clear_err);
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_tready", 32'(tready), 32'(model_tready(m, ready_en)));
      check("cyc_x", 32'(x), 32'(m.pix % X));
      check("cyc_y", 32'(y), 32'(m.pix / X));
      check("cyc_frame_done", 32'(frame_done), 32'(m.done));
      check("cyc_frame_count", 32'(frame_count), 32'(m.count));
      check("cyc_checksum", frame_checksum, m.cks);
      check("cyc_err_flags", 32'(err_flags), 32'(m.flags));
      check("cyc_err_count", 32'(err_count), 32'(m.errs));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all start and end 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [31:0] d, input bit u, input bit l, input logic [3:0] k);
    bit ok = 1'b0;
    int n  = 0;
    tdata  = d;
    tuser  = u;
    tlast  = l;
    tkeep  = k;
    tvalid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = tready;
      @(posedge clk);
      #1;
      n++;
    end
    tvalid = 1'b0;
    check("beat_accepted", 32'(ok), 32'd1);
  endtask

  task automatic send_clean_frame();
    for (int i = 0; i < NPX; i++)
      beat(32'((i % X) + 16 * (i / X)), i == 0, (i % X) == X - 1, 4'hF);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    idle(1);
    clear_err = 1'b0;
  endtask

  // ready_en pattern: 0 = always on, 1 = toggle every 3 cycles, 2 = random
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ready_en = 1'b1;
        1:       begin cnt++; if (cnt % 3 == 0) ready_en = ~ready_en; end
        default: ready_en = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] d;
    bit          u, l;
    logic [3:0]  k;
    int          r;

    rst_n = 1'b0; clear_err = 1'b0;
    tvalid = 1'b1; tdata = 32'h1234; tkeep = 4'hF; tlast = 1'b0; tuser = 1'b1;

    // Hold reset for two cycles with tvalid high.
    @(posedge clk);
    cmp_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_tready", 32'(tready), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_err_flags", 32'(err_flags), 32'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    tvalid = 1'b0;
    idle(1);
    check("post_rst_tready", 32'(tready), 32'd1);

    // Clean frame: sum of x+16*y over the 4x2 frame is 0x4C.
    send_clean_frame();
    check("clean_frame_done", 32'(frame_done), 32'd1);
    check("clean_frame_count", 32'(frame_count), 32'd1);
    check("clean_checksum", frame_checksum, 32'h4C);
    check("clean_err_flags", 32'(err_flags), 32'd0);
    idle(1);
    check("clean_done_pulse_ends", 32'(frame_done), 32'd0);

    // The same frame under host stalls produces the same result.
    do_reset();
    rdy_mode = 1;
    send_clean_frame();
    check("bp_frame_count", 32'(frame_count), 32'd1);
    check("bp_checksum", frame_checksum, 32'h4C);
    check("bp_err_flags", 32'(err_flags), 32'd0);
    rdy_mode = 0;
    idle(2);

    // tuser on beat 5 restarts the frame, and a clean frame follows from there.
    do_reset();
    for (int i = 0; i < 5; i++)
      beat(32'((i % X) + 16 * (i / X)), i == 0, (i % X) == X - 1, 4'hF);
    send_clean_frame();
    check("early_tuser_flags", 32'(err_flags), 32'b0001);
    check("early_tuser_err_count", 32'(err_count), 32'd1);
    check("early_tuser_frame_count", 32'(frame_count), 32'd1);
    check("early_tuser_checksum", frame_checksum, 32'h4C);

    // tlast dropped on beat 3: beats 4..7 are drained and no frame completes.
    do_reset();
    for (int i = 0; i < NPX; i++)
      beat(32'((i % X) + 16 * (i / X)), i == 0, i == NPX - 1, 4'hF);
    check("miss_tlast_flags", 32'(err_flags), 32'b0010);
    check("miss_tlast_err_count", 32'(err_count), 32'd1);
    check("miss_tlast_frame_count", 32'(frame_count), 32'd0);
    check("miss_tlast_x", 32'(x), 32'd0);
    pulse_clear();
    check("clear_flags", 32'(err_flags), 32'd0);
    check("clear_err_count", 32'(err_count), 32'd0);

    // Reset after beat 2 of the second frame.
    do_reset();
    send_clean_frame();
    for (int i = 0; i < 3; i++)
      beat(32'((i % X) + 16 * (i / X)), i == 0, (i % X) == X - 1, 4'hF);
    rst_n = 1'b0;
    #1;
    check("midrst_frame_count", 32'(frame_count), 32'd0);
    check("midrst_checksum", frame_checksum, 32'd0);
    check("midrst_x", 32'(x), 32'd0);
    check("midrst_y", 32'(y), 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    send_clean_frame();
    check("midrst_next_frame_count", 32'(frame_count), 32'd1);

`ifndef PIXEL_SINK_BACKPRESSURE_EN
    // clear_err arrives in the same cycle as a new tkeep error.
    do_reset();
    beat(32'd5, 1'b1, 1'b1, 4'hF);
    check("unexp_tlast_flags", 32'(err_flags), 32'b0100);
    clear_err = 1'b1;
    tdata = 32'd9; tuser = 1'b1; tlast = 1'b0; tkeep = 4'h3; tvalid = 1'b1;
    idle(1);
    clear_err = 1'b0;
    tvalid = 1'b0;
    check("clr_and_err_flags", 32'(err_flags), 32'b1000);
    check("clr_and_err_count", 32'(err_count), 32'd1);
`endif

    // Randomized phase: random stalls, junk beats and injected errors.
    do_reset();
    rdy_mode = 2;
    for (int f = 0; f < 80; f++) begin
      repeat ($urandom_range(0, 2)) beat($urandom, 1'b0, 1'($urandom_range(0, 1)), 4'hF);
      if ($urandom_range(0, 9) == 0) pulse_clear();
      for (int i = 0; i < NPX; i++) begin
        d = $urandom;
        u = (i == 0);
        l = ((i % X) == X - 1);
        k = 4'hF;
        r = $urandom_range(0, 29);
        if (r == 0) k = 4'($urandom_range(0, 14));
        else if (r == 1) l = !l;
        else if (r == 2) u = !u;
        beat(d, u, l, k);
        idle($urandom_range(0, 1));
      end
    end
    rdy_mode = 0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
